// File: rtl/int_arbiter_pkg.sv
// Shared constants, config register map and FSM state type for the interrupt arbiter.
package int_arbiter_pkg;

  localparam int unsigned INT_BUS = 8;
  localparam logic [INT_BUS-1:0] INT_NONE = '0;

  localparam logic [3:0] ARB_ENABLE    = 4'd0;
  localparam logic [3:0] ARB_EDGE      = 4'd1;
  localparam logic [3:0] ARB_THRESH    = 4'd2;
  localparam logic [3:0] ARB_PENDING   = 4'd3;
  localparam logic [3:0] ARB_PRIO_BASE = 4'd4;

  typedef enum logic [2:0] {
    S_ARB_IDLE    = 3'b001,
    S_ARB_ASSERT  = 3'b010,
    S_ARB_SERVICE = 3'b100
  } arb_state_e;

endpackage

// File: rtl/int_arbiter_if.sv
// Config port plus claim/complete handshake between the core side and the arbiter.
interface int_arbiter_if #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned ID_W    = 3
);
  logic                cfg_we_i;
  logic [3:0]          cfg_addr_i;
  logic [31:0]         cfg_wdata_i;
  logic [31:0]         cfg_rdata_o;
  logic                claim_i;
  logic                complete_i;
  logic [ID_W-1:0]     complete_id_i;
  logic [NUM_SRC-1:0]  int_flag_o;
  logic [ID_W-1:0]     int_id_o;

  modport master (
    output cfg_we_i, cfg_addr_i, cfg_wdata_i, claim_i, complete_i, complete_id_i,
    input  cfg_rdata_o, int_flag_o, int_id_o
  );

  modport slave (
    input  cfg_we_i, cfg_addr_i, cfg_wdata_i, claim_i, complete_i, complete_id_i,
    output cfg_rdata_o, int_flag_o, int_id_o
  );
endinterface

// File: rtl/int_prio_sel.sv
// Combinational maximum-priority select over eligible sources; lowest index wins ties.
module int_prio_sel #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned PRIO_W  = 3,
  parameter int unsigned ID_W    = 3
) (
  input  logic [NUM_SRC-1:0]             elig_i,
  input  logic [NUM_SRC-1:0][PRIO_W-1:0] prio_i,
  output logic                           any_o,
  output logic [ID_W-1:0]                id_o
);

  logic              w_found;
  logic [ID_W-1:0]   w_id;
  logic [PRIO_W-1:0] w_best;

  always_comb begin
    w_found = 1'b0;
    w_id    = '0;
    w_best  = '0;
    // strict compare keeps the earlier (lower) index on equal priority
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (elig_i[i] && (!w_found || prio_i[i] > w_best)) begin
        w_found = 1'b1;
        w_id    = ID_W'(i);
        w_best  = prio_i[i];
      end
    end
  end

  assign any_o = w_found;
  assign id_o  = w_id;

endmodule

// File: rtl/int_arbiter.sv
// Priority interrupt arbiter: synchronizers, pending/active tracking, config regs and claim/complete FSM.
module int_arbiter
  import int_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC = INT_BUS,
  parameter int unsigned PRIO_W  = 3,
  parameter int unsigned ID_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src_i,
  int_arbiter_if.slave       bus
);

  logic [NUM_SRC-1:0]             r_enable, r_edge, r_pend, r_active;
  logic [PRIO_W-1:0]              r_thresh;
  logic [NUM_SRC-1:0][PRIO_W-1:0] r_prio;
  logic [NUM_SRC-1:0]             r_sync1, r_sync2, r_sync3;
  logic [NUM_SRC-1:0]             w_rise, w_elig;
  logic [NUM_SRC-1:0]             r_flag, w_flag_nxt;
  logic [ID_W-1:0]                r_id, w_id_nxt, w_sel_id;
  logic                           w_any, w_claim;
  logic [31:0]                    w_rdata;
  arb_state_e                     r_state, w_state_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_enable <= '0;
      r_edge   <= '0;
      r_thresh <= '0;
      r_prio   <= '0;
    end else if (bus.cfg_we_i) begin
      case (bus.cfg_addr_i)
        ARB_ENABLE: r_enable <= bus.cfg_wdata_i[NUM_SRC-1:0];
        ARB_EDGE:   r_edge   <= bus.cfg_wdata_i[NUM_SRC-1:0];
        ARB_THRESH: r_thresh <= bus.cfg_wdata_i[PRIO_W-1:0];
        default: begin
          for (int unsigned i = 0; i < NUM_SRC; i++)
            if (bus.cfg_addr_i == 4'(32'(ARB_PRIO_BASE) + i))
              r_prio[i] <= bus.cfg_wdata_i[PRIO_W-1:0];
        end
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    case (bus.cfg_addr_i)
      ARB_ENABLE:  w_rdata[NUM_SRC-1:0] = r_enable;
      ARB_EDGE:    w_rdata[NUM_SRC-1:0] = r_edge;
      ARB_THRESH:  w_rdata[PRIO_W-1:0]  = r_thresh;
      ARB_PENDING: w_rdata[NUM_SRC-1:0] = r_pend;
      default: begin
        for (int unsigned i = 0; i < NUM_SRC; i++)
          if (bus.cfg_addr_i == 4'(32'(ARB_PRIO_BASE) + i))
            w_rdata[PRIO_W-1:0] = r_prio[i];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
    end else begin
      r_sync1 <= irq_src_i;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_rise  = r_sync2 & ~r_sync3;
  assign w_claim = (r_state == S_ARB_ASSERT) && bus.claim_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend   <= '0;
      r_active <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        // a fresh rise in the claim cycle outranks the claim's clear
        if (r_edge[i]) begin
          if (w_rise[i])                            r_pend[i] <= 1'b1;
          else if (w_claim && r_id == ID_W'(i))     r_pend[i] <= 1'b0;
        end else begin
          r_pend[i] <= r_sync2[i];
        end
        if (bus.complete_i && bus.complete_id_i == ID_W'(i)) r_active[i] <= 1'b0;
        if (w_claim && r_id == ID_W'(i))                     r_active[i] <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++)
      w_elig[i] = r_pend[i] & r_enable[i] & ~r_active[i] & (r_prio[i] > r_thresh);
  end

  int_prio_sel #(
    .NUM_SRC (NUM_SRC),
    .PRIO_W  (PRIO_W),
    .ID_W    (ID_W)
  ) u_sel (
    .elig_i (w_elig),
    .prio_i (r_prio),
    .any_o  (w_any),
    .id_o   (w_sel_id)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_ARB_IDLE;
      r_flag  <= NUM_SRC'(INT_NONE);
      r_id    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_flag  <= w_flag_nxt;
      r_id    <= w_id_nxt;
    end
  end

  // r_id doubles as the latched winner for the whole assert/service span
  always_comb begin
    w_state_nxt = r_state;
    w_flag_nxt  = r_flag;
    w_id_nxt    = r_id;
    case (r_state)
      S_ARB_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_ARB_ASSERT;
          w_flag_nxt  = NUM_SRC'(1) << w_sel_id;
          w_id_nxt    = w_sel_id;
        end
      end
      S_ARB_ASSERT: begin
        if (bus.claim_i) begin
          w_state_nxt = S_ARB_SERVICE;
          w_flag_nxt  = NUM_SRC'(INT_NONE);
        end else if (!w_elig[r_id]) begin
          w_state_nxt = S_ARB_IDLE;
          w_flag_nxt  = NUM_SRC'(INT_NONE);
        end
      end
      S_ARB_SERVICE: begin
        if (bus.complete_i && bus.complete_id_i == r_id)
          w_state_nxt = S_ARB_IDLE;
      end
      default: begin
        w_state_nxt = S_ARB_IDLE;
        w_flag_nxt  = NUM_SRC'(INT_NONE);
      end
    endcase
  end

  assign bus.cfg_rdata_o = w_rdata;
  assign bus.int_flag_o  = r_flag;
  assign bus.int_id_o    = r_id;

endmodule

// File: tb/tb_int_arbiter.sv
// Randomized bench for int_arbiter against a cycle-level behavioural model of the arbitration rules.
module tb_int_arbiter;

  localparam int unsigned NS  = 8;
  localparam int unsigned PW  = 3;
  localparam int unsigned IW  = 3;
  localparam int unsigned MSK = (1 << NS) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NS-1:0] irq = '0;

  int_arbiter_if #(.NUM_SRC(NS), .ID_W(IW)) u_if ();

  int_arbiter #(.NUM_SRC(NS), .PRIO_W(PW), .ID_W(IW)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .irq_src_i (irq),
    .bus       (u_if)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // model: mode 0 = nothing offered, 1 = offered awaiting claim, 2 = being serviced
  int unsigned m_en, m_edge, m_thr, m_pend, m_act, m_flag, m_id;
  int unsigned m_prio[NS];
  int unsigned m_d1, m_d2, m_d3;
  int          m_mode;

  task automatic m_reset();
    m_en = 0; m_edge = 0; m_thr = 0; m_pend = 0; m_act = 0;
    m_flag = 0; m_id = 0; m_mode = 0;
    m_d1 = 0; m_d2 = 0; m_d3 = 0;
    for (int i = 0; i < NS; i++) m_prio[i] = 0;
  endtask

  function automatic int unsigned m_read(input int unsigned a);
    if (a == 0) return m_en;
    if (a == 1) return m_edge;
    if (a == 2) return m_thr;
    if (a == 3) return m_pend;
    if (a >= 4 && a < 4 + NS) return m_prio[a-4];
    return 0;
  endfunction

  function automatic bit m_is_elig(input int unsigned i);
    return ((m_pend >> i) & 1) == 1 && ((m_en >> i) & 1) == 1 &&
           ((m_act >> i) & 1) == 0 && m_prio[i] > m_thr;
  endfunction

  task automatic m_step(input int unsigned in_irq, input bit we, input int unsigned addr,
                        input int unsigned wd, input bit cl, input bit co, input int unsigned cid);
    int unsigned rise, npend, nact;
    int best, win;
    bit claimed;
    rise = m_d2 & ~m_d3 & MSK;
    best = -1; win = 0;
    for (int unsigned i = 0; i < NS; i++)
      if (m_is_elig(i) && int'(m_prio[i]) > best) begin
        best = int'(m_prio[i]); win = int'(i);
      end
    claimed = (m_mode == 1) && cl;
    npend = 0;
    for (int unsigned i = 0; i < NS; i++) begin
      bit b;
      if ((m_edge >> i) & 1) begin
        b = ((m_pend >> i) & 1) == 1;
        if (claimed && m_id == i) b = 0;
        if ((rise >> i) & 1) b = 1;
      end else b = ((m_d2 >> i) & 1) == 1;
      if (b) npend |= (1 << i);
    end
    nact = m_act;
    if (co) nact &= ~(32'd1 << cid);
    if (claimed) nact |= (1 << m_id);
    case (m_mode)
      0: if (best >= 0) begin m_mode = 1; m_flag = 1 << win; m_id = win; end
      1: if (cl) begin m_mode = 2; m_flag = 0; end
         else if (!m_is_elig(m_id)) begin m_mode = 0; m_flag = 0; end
      default: if (co && cid == m_id) m_mode = 0;
    endcase
    m_pend = npend;
    m_act  = nact & MSK;
    if (we) begin
      if (addr == 0) m_en = wd & MSK;
      else if (addr == 1) m_edge = wd & MSK;
      else if (addr == 2) m_thr = wd & ((1 << PW) - 1);
      else if (addr >= 4 && addr < 4 + NS) m_prio[addr-4] = wd & ((1 << PW) - 1);
    end
    m_d3 = m_d2; m_d2 = m_d1; m_d1 = in_irq & MSK;
  endtask

  // called at a falling edge; outputs are checked at the following falling edge
  task automatic apply(input logic [NS-1:0] i_irq, input logic we, input logic [3:0] addr,
                       input logic [31:0] wd, input logic cl, input logic co, input logic [IW-1:0] cid);
    irq = i_irq;
    u_if.cfg_we_i = we; u_if.cfg_addr_i = addr; u_if.cfg_wdata_i = wd;
    u_if.claim_i = cl; u_if.complete_i = co; u_if.complete_id_i = cid;
    #1;
    check("rdata", u_if.cfg_rdata_o, m_read(addr));
    m_step(i_irq, we, addr, wd, cl, co, cid);
    @(negedge clk);
    check("int_flag", 32'(u_if.int_flag_o), m_flag);
    check("int_id", 32'(u_if.int_id_o), m_id);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) apply(irq, 1'b0, 4'd3, 32'd0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    m_reset();
    check("rst_flag", 32'(u_if.int_flag_o), 0);
    check("rst_id", 32'(u_if.int_id_o), 0);
    for (int a = 0; a < 16; a++) begin
      u_if.cfg_addr_i = 4'(a);
      #1;
      check("rst_rdata", u_if.cfg_rdata_o, 0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic random_cycles(input int n);
    logic [NS-1:0] r_irq;
    logic          we, cl, co;
    logic [3:0]    addr;
    logic [31:0]   wd;
    logic [IW-1:0] cid;
    for (int k = 0; k < n; k++) begin
      r_irq = irq;
      for (int b = 0; b < NS; b++) if ($urandom_range(15) == 0) r_irq[b] = ~r_irq[b];
      we   = ($urandom_range(9) == 0);
      addr = 4'($urandom_range(15));
      wd   = $urandom;
      if (addr == 4'd2) wd = 32'($urandom_range(3));
      if (addr == 4'd0) wd = wd | 32'($urandom_range(255));
      cl = (m_flag != 0) ? ($urandom_range(2) == 0) : ($urandom_range(19) == 0);
      if (m_mode == 2) begin
        co  = ($urandom_range(3) == 0);
        cid = ($urandom_range(3) == 0) ? IW'($urandom_range(NS-1)) : IW'(m_id);
      end else begin
        co  = ($urandom_range(29) == 0);
        cid = IW'($urandom_range(NS-1));
      end
      apply(r_irq, we, addr, wd, cl, co, cid);
    end
  endtask

  initial begin
    u_if.cfg_we_i = 1'b0; u_if.cfg_addr_i = '0; u_if.cfg_wdata_i = '0;
    u_if.claim_i = 1'b0; u_if.complete_i = 1'b0; u_if.complete_id_i = '0;
    @(negedge clk);
    do_reset();

    // edge source 2 at priority 5, single pulse, then claim and complete
    apply('0, 1'b1, 4'd6, 32'd5, 1'b0, 1'b0, '0);
    apply('0, 1'b1, 4'd0, 32'h04, 1'b0, 1'b0, '0);
    apply('0, 1'b1, 4'd1, 32'h04, 1'b0, 1'b0, '0);
    apply(8'h04, 1'b0, 4'd3, 32'd0, 1'b0, 1'b0, '0);
    apply(8'h00, 1'b0, 4'd3, 32'd0, 1'b0, 1'b0, '0);
    idle(4);
    check("t1_flag", 32'(u_if.int_flag_o), 32'h04);
    apply('0, 1'b0, 4'd3, 32'd0, 1'b1, 1'b0, '0);
    apply('0, 1'b0, 4'd3, 32'd0, 1'b0, 1'b1, 3'd6);
    apply('0, 1'b0, 4'd3, 32'd0, 1'b0, 1'b1, 3'd2);
    idle(2);

    // threshold boundary: PRIO[0]=4 level source, THRESHOLD 4 then 3
    apply('0, 1'b1, 4'd4, 32'd4, 1'b0, 1'b0, '0);
    apply('0, 1'b1, 4'd0, 32'h05, 1'b0, 1'b0, '0);
    apply('0, 1'b1, 4'd2, 32'd4, 1'b0, 1'b0, '0);
    apply(8'h01, 1'b0, 4'd3, 32'd0, 1'b0, 1'b0, '0);
    idle(5);
    apply(irq, 1'b1, 4'd2, 32'd3, 1'b0, 1'b0, '0);
    idle(3);
    check("t4_flag", 32'(u_if.int_flag_o), 32'h01);
    apply(8'h00, 1'b0, 4'd3, 32'd0, 1'b0, 1'b0, '0);
    idle(5);

    random_cycles(3000);
    do_reset();
    idle(6);
    random_cycles(3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
